conv554_seq: RTL and testbench
==============================

CONV554_SEQ -- requirements
Module: conv554_seq

Interface
REQ-001 Parameter BIT_WIDTH, default 8: width of pixel, weight and bias.
REQ-002 Parameter OUT_WIDTH, default 32: width of conv result and output.
REQ-003 Parameter IMG_W, default 32: input map width in pixels; legal range 5..1023.
REQ-004 Parameter IMG_H, default 32: input map height in pixels; legal range 5..1023.
REQ-005 Parameter LAT, default 2: cycles from conv_en column issue to matching conv_value; legal range 1..8.
REQ-006 Port clk  input  1  sole clock; all state changes on its rising edge.
REQ-007 Port rst  input  1  reset; synchronous and active-high.
REQ-008 Port start  input  1  one-cycle pulse that begins a map; honoured only in IDLE.
REQ-009 Port busy  output  1  high in any state other than IDLE.
REQ-010 Port done  output  1  one-cycle pulse after the last output is accepted.
REQ-011 Port rd_row  output  10  top row of the 5-row column being fed to the 4-channel conv unit.
REQ-012 Port rd_col  output  10  column index being fed this cycle.
REQ-013 Port conv_en  output  1  latch enable driven to the conv unit; high means a column is shifted in this cycle.
REQ-014 Port conv_value  input  OUT_WIDTH  signed sum of the four 5x5 channel convolutions, bias excluded.
REQ-015 Port bias  input  BIT_WIDTH  signed bias; must be held stable while busy.
REQ-016 Port out_valid  output  1  out_data is a valid result.
REQ-017 Port out_ready  input  1  consumer accepts; transfer occurs when out_valid and out_ready are both high.
REQ-018 Port out_data  output  OUT_WIDTH  signed result: conv_value plus sign-extended bias.
REQ-019 Port out_row, out_col  output  10 each  output-pixel coordinates of out_data.

Function
REQ-020 FSM states: IDLE, FEED, DRAIN, DONE.
REQ-021 IDLE to FEED on start; rd_row and rd_col clear to 0.
REQ-022 FEED: each unstalled cycle asserts conv_en and increments rd_col; after rd_col = IMG_W-1 is issued, the FSM moves to DRAIN.
REQ-023 A column issue is window-complete when rd_col >= 4; window-complete is tagged into a LAT-deep valid shift register that advances only on unstalled cycles.
REQ-024 out_valid equals the tail of the tag register; out_col = issued column - 4; out_row = rd_row of that issue.
REQ-025 A stall is the cycle condition out_valid and not out_ready; during a stall conv_en = 0, and all counters, tags, out_data and coordinates hold.
REQ-026 DRAIN: LAT unstalled cycles with conv_en = 0 and no tags inserted; then, if rd_row < IMG_H-5, rd_row increments, rd_col clears and the FSM returns to FEED; otherwise it goes to DONE.
REQ-027 DONE: done = 1 for one cycle, then IDLE.
REQ-028 Outputs per map are exactly (IMG_H-4)*(IMG_W-4), in raster order, with none dropped or duplicated under any out_ready pattern.
REQ-029 Addition uses the OUT_WIDTH two's-complement result and wraps on overflow, with no saturation.
REQ-030 A start pulse while busy is ignored.
REQ-031 When IMG_W = 5, each row yields exactly 1 output.

Reset
REQ-032 rst, sampled at a rising edge, forces IDLE from any state, including mid-row and mid-stall.
REQ-033 rst clears every output and internal register to 0: busy, done, conv_en, out_valid, out_data, out_row, out_col, rd_row, rd_col, and the tags.

Configuration
REQ-034 Macro CONV554_SEQ_RELU_EN defined: out_data = 0 whenever conv_value + bias is negative.
REQ-035 Macro CONV554_SEQ_RELU_EN undefined: out_data is the raw signed sum.
REQ-036 Timing and handshake are identical with and without CONV554_SEQ_RELU_EN.

Structure
REQ-037 A shared package holds the FSM state enum, the kernel-size constant (5) and the coordinate width (10).
REQ-038 Sub-module conv554_seq_vpipe holds the LAT-deep stall-aware tag and coordinate pipeline; the FSM, counters and bias adder stay in the top module.

Verification
REQ-039 IMG_W=8, IMG_H=6, LAT=2, out_ready=1, start -> 8 outputs, (0,0)..(1,3) raster; first out_valid 7 cycles after FEED entry; one-cycle done.
REQ-040 Bench model: conv_value = issued rd_col*10 delayed LAT; bias = -3 -> out_data at out_col 0 equals 37, at out_col 3 equals 67.
REQ-041 out_ready toggled 0/1 every other cycle -> same 8 values and order as REQ-039; conv_en = 0 on every stall cycle.
REQ-042 rst asserted at the 3rd output -> next cycle busy = 0, out_valid = 0, conv_en = 0; a fresh start then produces the full 8 outputs.
REQ-043 With CONV554_SEQ_RELU_EN: conv_value = -100, bias = 5 -> out_data = 0. Without it: the same stimulus -> out_data = -95.
REQ-044 start pulsed again mid-map and IMG_W = 5, IMG_H = 5 -> the second start is ignored, and the small map yields exactly 1 output then done.

Source files
------------

// File: rtl/conv554_seq_pkg.sv
// Shared types and constants for the conv554_seq 5x5 sliding-window sequencer.
package conv554_seq_pkg;

  localparam int KSIZE   = 5;
  localparam int COORD_W = 10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FEED  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  typedef struct packed {
    logic               valid;
    logic [COORD_W-1:0] row;
    logic [COORD_W-1:0] col;
  } tag_t;

endpackage

// File: rtl/conv554_seq_vpipe.sv
// LAT-deep tag/coordinate pipeline that tracks columns in flight through the conv unit.
module conv554_seq_vpipe
  import conv554_seq_pkg::*;
#(
  parameter int LAT = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic adv_i,
  input  tag_t tag_i,
  output tag_t tail_o
);

  tag_t [LAT:0] chain;

  assign chain[0] = tag_i;

  // Every stage moves together; a stall freezes the whole pipe in step with the conv unit.
  for (genvar gi = 0; gi < LAT; gi++) begin : g_stage
    tag_t stage_q;

    always_ff @(posedge clk) begin
      if (rst) begin
        stage_q <= '0;
      end else if (adv_i) begin
        stage_q <= chain[gi];
      end
    end

    assign chain[gi+1] = stage_q;
  end

  assign tail_o = chain[LAT];

endmodule

// File: rtl/conv554_seq.sv
// Feeds image columns to a 4-channel 5x5 conv unit and emits biased results with a valid/ready handshake.
// Optional clamp of negative results to zero when CONV554_SEQ_RELU_EN is defined.
module conv554_seq
  import conv554_seq_pkg::*;
#(
  parameter int BIT_WIDTH = 8,
  parameter int OUT_WIDTH = 32,
  parameter int IMG_W     = 32,
  parameter int IMG_H     = 32,
  parameter int LAT       = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  output logic                        busy,
  output logic                        done,
  output logic [COORD_W-1:0]          rd_row,
  output logic [COORD_W-1:0]          rd_col,
  output logic                        conv_en,
  input  logic signed [OUT_WIDTH-1:0] conv_value,
  input  logic signed [BIT_WIDTH-1:0] bias,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic signed [OUT_WIDTH-1:0] out_data,
  output logic [COORD_W-1:0]          out_row,
  output logic [COORD_W-1:0]          out_col
);

  localparam logic [COORD_W-1:0] LAST_COL   = COORD_W'(IMG_W - 1);
  localparam logic [COORD_W-1:0] LAST_ROW   = COORD_W'(IMG_H - KSIZE);
  localparam logic [COORD_W-1:0] FIRST_WIN  = COORD_W'(KSIZE - 1);
  localparam logic [3:0]         LAST_DRAIN = 4'(LAT - 1);

  state_e             state_q, state_d;
  logic [COORD_W-1:0] row_q, row_d;
  logic [COORD_W-1:0] col_q, col_d;
  logic [3:0]         drain_q, drain_d;

  logic                        out_valid_q;
  logic signed [OUT_WIDTH-1:0] out_data_q;
  logic [COORD_W-1:0]          out_row_q;
  logic [COORD_W-1:0]          out_col_q;

  logic                        stall;
  logic                        issue;
  tag_t                        tag_in;
  tag_t                        tail;
  logic signed [OUT_WIDTH-1:0] bias_ext;
  logic signed [OUT_WIDTH-1:0] sum;
  logic signed [OUT_WIDTH-1:0] result;

  assign stall = out_valid_q && !out_ready;
  assign issue = (state_q == ST_FEED) && !stall;

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    drain_d = drain_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_FEED;
          row_d   = '0;
          col_d   = '0;
        end
      end
      ST_FEED: begin
        if (!stall) begin
          if (col_q == LAST_COL) begin
            state_d = ST_DRAIN;
            drain_d = '0;
          end else begin
            col_d = col_q + 1'b1;
          end
        end
      end
      ST_DRAIN: begin
        if (!stall) begin
          if (drain_q == LAST_DRAIN) begin
            if (row_q < LAST_ROW) begin
              state_d = ST_FEED;
              row_d   = row_q + 1'b1;
              col_d   = '0;
            end else begin
              state_d = ST_DONE;
            end
          end else begin
            drain_d = drain_q + 1'b1;
          end
        end
      end
      ST_DONE: begin
        // Hold here until the final result has left the output register.
        if (!out_valid_q) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      row_q   <= '0;
      col_q   <= '0;
      drain_q <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      drain_q <= drain_d;
    end
  end

  assign tag_in.valid = issue && (col_q >= FIRST_WIN);
  assign tag_in.row   = row_q;
  assign tag_in.col   = col_q - FIRST_WIN;

  conv554_seq_vpipe #(
    .LAT (LAT)
  ) u_vpipe (
    .clk    (clk),
    .rst    (rst),
    .adv_i  (!stall),
    .tag_i  (tag_in),
    .tail_o (tail)
  );

  assign bias_ext = OUT_WIDTH'(bias);
  assign sum      = conv_value + bias_ext;

`ifdef CONV554_SEQ_RELU_EN
  assign result = sum[OUT_WIDTH-1] ? '0 : sum;
`else
  assign result = sum;
`endif

  // conv_value lines up with the tag arriving at the pipe tail; capture both together.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_row_q   <= '0;
      out_col_q   <= '0;
    end else if (!stall) begin
      out_valid_q <= tail.valid;
      if (tail.valid) begin
        out_data_q <= result;
        out_row_q  <= tail.row;
        out_col_q  <= tail.col;
      end
    end
  end

  assign busy      = (state_q != ST_IDLE);
  assign done      = (state_q == ST_DONE) && !out_valid_q;
  assign rd_row    = row_q;
  assign rd_col    = col_q;
  assign conv_en   = issue;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_row   = out_row_q;
  assign out_col   = out_col_q;

endmodule

// File: tb/tb_conv554_seq.sv
// Self-checking bench for conv554_seq: an 8x6 map (LAT=2) and a 5x5 map (LAT=3) instance.
module tb_conv554_seq;

  typedef struct {
    logic signed [31:0] data;
    int                 row;
    int                 col;
  } exp_t;

  typedef struct {
    logic signed [31:0] cv;
    logic signed [7:0]  b;
    logic signed [31:0] exp_out;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start_m = 1'b0;
  logic start_s = 1'b0;
  logic out_ready = 1'b1;
  logic signed [7:0] bias = '0;

  logic busy_m, done_m, conv_en_m, out_valid_m;
  logic [9:0] rd_row_m, rd_col_m, out_row_m, out_col_m;
  logic signed [31:0] conv_value_m, out_data_m;
  logic busy_s, done_s, conv_en_s, out_valid_s;
  logic [9:0] rd_row_s, rd_col_s, out_row_s, out_col_s;
  logic signed [31:0] conv_value_s, out_data_s;

  int errors = 0;
  int checks = 0;
  int mode = 0;
  int ready_mode = 0;
  logic signed [31:0] cv_const = '0;
  logic signed [31:0] tab [8][8];
  exp_t q_m[$];
  exp_t q_s[$];
  exp_t e_m, e_s;
  int acc_m = 0, acc_s = 0, done_cnt_m = 0, done_cnt_s = 0;
  logic signed [31:0] d_col0, d_col3, last_data_s;

  always #5 clk = ~clk;

  conv554_seq #(.BIT_WIDTH(8), .OUT_WIDTH(32), .IMG_W(8), .IMG_H(6), .LAT(2)) dut (
    .clk(clk), .rst(rst), .start(start_m), .busy(busy_m), .done(done_m),
    .rd_row(rd_row_m), .rd_col(rd_col_m), .conv_en(conv_en_m), .conv_value(conv_value_m),
    .bias(bias), .out_valid(out_valid_m), .out_ready(out_ready), .out_data(out_data_m),
    .out_row(out_row_m), .out_col(out_col_m));

  conv554_seq #(.BIT_WIDTH(8), .OUT_WIDTH(32), .IMG_W(5), .IMG_H(5), .LAT(3)) dut_s (
    .clk(clk), .rst(rst), .start(start_s), .busy(busy_s), .done(done_s),
    .rd_row(rd_row_s), .rd_col(rd_col_s), .conv_en(conv_en_s), .conv_value(conv_value_s),
    .bias(bias), .out_valid(out_valid_s), .out_ready(out_ready), .out_data(out_data_s),
    .out_row(out_row_s), .out_col(out_col_s));

  // Value the conv unit produces for the column whose top-left is (r, c).
  function automatic logic signed [31:0] model_val(int r, int c);
    case (mode)
      0:       return 32'(c * 10);
      1:       return cv_const;
      default: return tab[r][c];
    endcase
  endfunction

  function automatic logic signed [31:0] ref_out(logic signed [31:0] cv, logic signed [7:0] b);
    logic signed [31:0] s;
    s = 32'(longint'(cv) + longint'(b));
`ifdef CONV554_SEQ_RELU_EN
    if (s < 0) s = 0;
`endif
    return s;
  endfunction

  // Behavioural conv units: LAT-deep, frozen while the consumer stalls.
  logic signed [31:0] cp_m [2];
  logic signed [31:0] cp_s [3];
  always @(posedge clk) begin
    if (rst) begin
      cp_m[0] <= '0; cp_m[1] <= '0;
    end else if (!(out_valid_m && !out_ready)) begin
      cp_m[0] <= conv_en_m ? model_val(int'(rd_row_m), int'(rd_col_m)) : 32'sd0;
      cp_m[1] <= cp_m[0];
    end
  end
  always @(posedge clk) begin
    if (rst) begin
      cp_s[0] <= '0; cp_s[1] <= '0; cp_s[2] <= '0;
    end else if (!(out_valid_s && !out_ready)) begin
      cp_s[0] <= conv_en_s ? model_val(int'(rd_row_s), int'(rd_col_s)) : 32'sd0;
      cp_s[1] <= cp_s[0];
      cp_s[2] <= cp_s[1];
    end
  end
  assign conv_value_m = cp_m[1];
  assign conv_value_s = cp_s[2];

  always @(posedge clk) begin
    #1;
    if (ready_mode == 1) out_ready = ~out_ready;
    else if (ready_mode == 2) out_ready = 1'($urandom_range(0, 1));
  end

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboards: every accepted transfer is matched against the raster-order expectation.
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid_m && !out_ready) begin
        checks++;
        if (conv_en_m !== 1'b0) begin
          errors++;
          $display("FAIL stall_conv_en_m: got %b expected 0", conv_en_m);
        end
      end
      if (out_valid_m && out_ready) begin
        checks++;
        acc_m++;
        if (q_m.size() == 0) begin
          errors++;
          $display("FAIL extra_out_m: got (%0d,%0d)=%0d expected none", out_row_m, out_col_m, out_data_m);
        end else begin
          e_m = q_m.pop_front();
          if (out_data_m !== e_m.data || out_row_m !== 10'(e_m.row) || out_col_m !== 10'(e_m.col)) begin
            errors++;
            $display("FAIL out_m: got (%0d,%0d)=%0d expected (%0d,%0d)=%0d",
                     out_row_m, out_col_m, out_data_m, e_m.row, e_m.col, e_m.data);
          end else begin
            $display("xfer m (%0d,%0d) = %0d", out_row_m, out_col_m, out_data_m);
          end
        end
        if (out_row_m == 0 && out_col_m == 0) d_col0 = out_data_m;
        if (out_row_m == 0 && out_col_m == 3) d_col3 = out_data_m;
      end
      if (done_m) done_cnt_m++;

      if (out_valid_s && !out_ready) begin
        checks++;
        if (conv_en_s !== 1'b0) begin
          errors++;
          $display("FAIL stall_conv_en_s: got %b expected 0", conv_en_s);
        end
      end
      if (out_valid_s && out_ready) begin
        checks++;
        acc_s++;
        last_data_s = out_data_s;
        if (q_s.size() == 0) begin
          errors++;
          $display("FAIL extra_out_s: got (%0d,%0d)=%0d expected none", out_row_s, out_col_s, out_data_s);
        end else begin
          e_s = q_s.pop_front();
          if (out_data_s !== e_s.data || out_row_s !== 10'(e_s.row) || out_col_s !== 10'(e_s.col)) begin
            errors++;
            $display("FAIL out_s: got (%0d,%0d)=%0d expected (%0d,%0d)=%0d",
                     out_row_s, out_col_s, out_data_s, e_s.row, e_s.col, e_s.data);
          end else begin
            $display("xfer s (%0d,%0d) = %0d", out_row_s, out_col_s, out_data_s);
          end
        end
      end
      if (done_s) done_cnt_s++;
    end
  end

  task automatic push_map(bit sm);
    int w, h;
    exp_t e;
    w = sm ? 5 : 8;
    h = sm ? 5 : 6;
    for (int r = 0; r <= h - 5; r++) begin
      for (int c = 0; c <= w - 5; c++) begin
        e.data = ref_out(model_val(r, c + 4), bias);
        e.row  = r;
        e.col  = c;
        if (sm) q_s.push_back(e); else q_m.push_back(e);
      end
    end
  endtask

  task automatic pulse_start(bit sm);
    @(negedge clk);
    if (sm) start_s = 1'b1; else start_m = 1'b1;
    @(negedge clk);
    start_s = 1'b0;
    start_m = 1'b0;
  endtask

  task automatic wait_done(bit sm, string name);
    int n;
    n = 0;
    while (!(sm ? done_s : done_m) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_done_seen"}, 64'(sm ? done_s : done_m), 64'd1);
    @(negedge clk);
    chk({name, "_done_width"}, 64'(sm ? done_s : done_m), 64'd0);
    chk({name, "_idle"}, 64'(sm ? busy_s : busy_m), 64'd0);
    chk({name, "_queue_empty"}, 64'(sm ? q_s.size() : q_m.size()), 64'd0);
  endtask

  vec_t vecs[6];

  initial begin
    int a0, dc0, k, n;
    vecs[0] = '{cv: -32'sd100, b: 8'sd5, exp_out: 32'sd0};
    vecs[1] = '{cv: 32'sd40, b: -8'sd3, exp_out: 32'sd37};
    vecs[2] = '{cv: 32'sh7FFFFFFF, b: 8'sd1, exp_out: 32'sh80000000};
    vecs[3] = '{cv: -32'sd2, b: 8'sd1, exp_out: -32'sd1};
    vecs[4] = '{cv: 32'sd0, b: -8'sd128, exp_out: -32'sd128};
    vecs[5] = '{cv: 32'sh7FFFFF00, b: 8'sd127, exp_out: 32'sh7FFFFF7F};
`ifdef CONV554_SEQ_RELU_EN
    vecs[0].exp_out = 32'sd0;
    vecs[2].exp_out = 32'sd0;
    vecs[3].exp_out = 32'sd0;
    vecs[4].exp_out = 32'sd0;
`else
    vecs[0].exp_out = -32'sd95;
`endif

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_busy_m", 64'(busy_m), 0);       chk("rst_done_m", 64'(done_m), 0);
    chk("rst_conv_en_m", 64'(conv_en_m), 0); chk("rst_out_valid_m", 64'(out_valid_m), 0);
    chk("rst_out_data_m", 64'(out_data_m), 0);
    chk("rst_out_row_m", 64'(out_row_m), 0); chk("rst_out_col_m", 64'(out_col_m), 0);
    chk("rst_rd_row_m", 64'(rd_row_m), 0);   chk("rst_rd_col_m", 64'(rd_col_m), 0);
    chk("rst_busy_s", 64'(busy_s), 0);       chk("rst_out_valid_s", 64'(out_valid_s), 0);
    rst = 1'b0;

    // Basic 8x6 map, ready always high, first-output latency
    mode = 0; bias = -8'sd3; ready_mode = 0; out_ready = 1'b1;
    push_map(0);
    a0 = acc_m; dc0 = done_cnt_m;
    pulse_start(0);
    k = 0;
    while (!out_valid_m && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk("first_valid_latency", 64'(k), 64'd7);
    wait_done(0, "basic");
    chk("basic_count", 64'(acc_m - a0), 64'd8);
    chk("basic_done_pulses", 64'(done_cnt_m - dc0), 64'd1);
    chk("basic_col0_value", 64'(d_col0), 64'(32'sd37));
    chk("basic_col3_value", 64'(d_col3), 64'(32'sd67));

    // Toggling ready
    ready_mode = 1;
    push_map(0);
    a0 = acc_m;
    pulse_start(0);
    wait_done(0, "toggle");
    chk("toggle_count", 64'(acc_m - a0), 64'd8);
    ready_mode = 0;
    @(negedge clk);
    out_ready = 1'b1;

    // Reset on the third output, then a fresh map
    push_map(0);
    a0 = acc_m;
    pulse_start(0);
    n = 0;
    while (!(acc_m == a0 + 2 && out_valid_m) && n < 500) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("rst_mid_reached", 64'(n < 500), 64'd1);
    rst = 1'b1;
    out_ready = 1'b0;
    q_m.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_mid_busy", 64'(busy_m), 0);
    chk("rst_mid_out_valid", 64'(out_valid_m), 0);
    chk("rst_mid_conv_en", 64'(conv_en_m), 0);
    chk("rst_mid_rd_col", 64'(rd_col_m), 0);
    out_ready = 1'b1;
    push_map(0);
    a0 = acc_m;
    pulse_start(0);
    wait_done(0, "after_rst");
    chk("after_rst_count", 64'(acc_m - a0), 64'd8);

    // Small map with a second start while busy
    push_map(1);
    a0 = acc_s; dc0 = done_cnt_s;
    pulse_start(1);
    @(negedge clk);
    start_s = 1'b1;
    @(negedge clk);
    start_s = 1'b0;
    wait_done(1, "small");
    repeat (20) @(negedge clk);
    chk("small_count", 64'(acc_s - a0), 64'd1);
    chk("small_done_pulses", 64'(done_cnt_s - dc0), 64'd1);
    chk("small_still_idle", 64'(busy_s), 0);

    // Table of arithmetic corner cases through the small map
    mode = 1;
    for (int i = 0; i < 6; i++) begin
      cv_const = vecs[i].cv;
      bias = vecs[i].b;
      push_map(1);
      pulse_start(1);
      wait_done(1, $sformatf("vec%0d", i));
      chk($sformatf("vec%0d_data", i), 64'(last_data_s), 64'(vecs[i].exp_out));
    end

    // Random conv values, bias and backpressure on both instances
    mode = 2;
    ready_mode = 2;
    for (int m = 0; m < 4; m++) begin
      for (int r = 0; r < 8; r++)
        for (int c = 0; c < 8; c++)
          tab[r][c] = $urandom;
      bias = 8'($urandom);
      push_map(0);
      push_map(1);
      a0 = acc_m;
      dc0 = acc_s;
      pulse_start(0);
      pulse_start(1);
      wait_done(0, $sformatf("rand%0d_m", m));
      n = 0;
      while (busy_s && n < 500) begin
        @(negedge clk);
        n++;
      end
      chk($sformatf("rand%0d_count_m", m), 64'(acc_m - a0), 64'd8);
      chk($sformatf("rand%0d_count_s", m), 64'(acc_s - dc0), 64'd1);
      chk($sformatf("rand%0d_queue_s", m), 64'(q_s.size()), 64'd0);
    end
    ready_mode = 0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
